// File: rtl/hsaf_adapt_sched.sv
`default_nettype none
// hsaf_adapt_sched: slot scheduler, LAT-deep tag pipeline, phase FSM and windowed |error| convergence monitor.
// Build option HSAF_AUTO_FREEZE_EN: a converged TRACK phase freezes adaptation without freeze_req.
module hsaf_adapt_sched #(
  parameter int WIDTH   = 16,
  parameter int LAT     = 10,
  parameter int N_TRAIN = 4096,
  parameter int WIN_LOG = 8,
  parameter int ERR_THR = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             freeze_req,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_signal,
  input  logic [WIDTH-1:0] s_desired,
  output logic [WIDTH-1:0] dp_signal_in,
  output logic [WIDTH-1:0] dp_desired_in,
  output logic             dp_adapt_en,
  input  logic [WIDTH-1:0] dp_filter_out_d,
  input  logic [WIDTH-1:0] dp_error_d,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_filter_out,
  output logic [WIDTH-1:0] m_error,
  output logic [2:0]       state,
  output logic             converged
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_TRAIN  = 3'd2,
    S_TRACK  = 3'd3,
    S_FREEZE = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  localparam int CW = $clog2(N_TRAIN + 1);
  localparam int AW = WIDTH + WIN_LOG;

  state_t             state_q, state_d;
  logic [LAT:1]       tag_q;
  logic [WIDTH-1:0]   sig_q, des_q, mfo_q, merr_q;
  logic               mval_q;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0]      acc_q, acc_d, acc_sum;
  logic [WIN_LOG-1:0] wcnt_q, wcnt_d;
  logic               conv_q, conv_d;
  logic               dfrz_q, dfrz_d;
  logic               accept, tag_lat, running, monitor, auto_frz;
  logic [WIDTH-1:0]   abs_e;

`ifdef HSAF_AUTO_FREEZE_EN
  assign auto_frz = conv_q;
`else
  assign auto_frz = 1'b0;
`endif

  assign running = state_q inside {S_FILL, S_TRAIN, S_TRACK, S_FREEZE};
  assign s_ready = running;
  assign accept  = s_valid && s_ready;
  assign tag_lat = tag_q[LAT];
  assign monitor = mval_q && (state_q inside {S_TRAIN, S_TRACK, S_FREEZE});

  // FILL with a slot at tag[LAT] is already the first TRAIN slot, so it adapts.
  assign dp_adapt_en = tag_lat &&
                       ((state_q inside {S_FILL, S_TRAIN, S_TRACK}) ||
                        (state_q == S_DRAIN && !dfrz_q));

  always_comb begin
    abs_e = merr_q;
    if (merr_q[WIDTH-1]) begin
      if (merr_q == {1'b1, {(WIDTH-1){1'b0}}}) abs_e = {1'b0, {(WIDTH-1){1'b1}}};
      else                                      abs_e = -merr_q;
    end
  end

  assign acc_sum = acc_q + AW'(abs_e);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dfrz_d  = dfrz_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    conv_d  = conv_q;
    cnt_inc = cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          cnt_d   = '0;
          acc_d   = '0;
          wcnt_d  = '0;
          conv_d  = 1'b0;
        end
      end
      S_FILL, S_TRAIN: begin
        // A freeze request raised during training takes effect as training ends.
        if (tag_lat) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(N_TRAIN)) state_d = freeze_req ? S_FREEZE : S_TRACK;
          else                         state_d = S_TRAIN;
        end
      end
      S_TRACK:  if (freeze_req || auto_frz)   state_d = S_FREEZE;
      S_FREEZE: if (!freeze_req && !auto_frz) state_d = S_TRACK;
      S_DRAIN:  if (tag_q == '0)              state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (stop && running) begin
      state_d = S_DRAIN;
      dfrz_d  = (state_q == S_FREEZE);
    end
    if (monitor) begin
      wcnt_d = wcnt_q + WIN_LOG'(1);
      if (&wcnt_q) begin
        conv_d = (acc_sum >> WIN_LOG) < AW'(ERR_THR);
        acc_d  = '0;
      end else begin
        acc_d  = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      sig_q   <= '0;
      des_q   <= '0;
      mval_q  <= 1'b0;
      mfo_q   <= '0;
      merr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      conv_q  <= 1'b0;
      dfrz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= (tag_q << 1) | LAT'(accept);
      sig_q   <= accept ? s_signal  : '0;
      des_q   <= accept ? s_desired : '0;
      mval_q  <= tag_lat;
      if (tag_lat) begin
        mfo_q  <= dp_filter_out_d;
        merr_q <= dp_error_d;
      end
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      conv_q  <= conv_d;
      dfrz_q  <= dfrz_d;
    end
  end

  assign dp_signal_in  = sig_q;
  assign dp_desired_in = des_q;
  assign m_valid       = mval_q;
  assign m_filter_out  = mfo_q;
  assign m_error       = merr_q;
  assign state         = state_q;
  assign converged     = conv_q;

endmodule
`default_nettype wire

// File: doc/hsaf_adapt_sched.md
Name: hsaf_adapt_sched

Overview:
- Sample-stream scheduler in front of the hybrid spline adaptive filter datapath (nonlinear spline stage, then linear LMS FIR).
- Accepts (signal, desired) pairs over a valid/ready handshake and feeds the free-running datapath one slot per clock, inserting zero bubbles when no sample is available.
- Tags every slot through a LAT-deep valid pipeline so that filter output and error return aligned, and gates adaptation per slot (mu-error gate).
- Sequences fill, training, tracking, freeze and drain phases, and raises a converged flag from the windowed mean |error|.

Parameters:
- WIDTH, 16, sample/error width, signed Q(WIDTH-QP).QP two's complement.
- LAT, 10, clocks from a slot driven on dp_signal_in to its dp_error_d/dp_filter_out_d being valid.
- N_TRAIN, 4096, tagged outputs adapted in TRAIN before moving to TRACK; must be >= 1.
- WIN_LOG, 8, convergence window = 2^WIN_LOG tagged outputs.
- ERR_THR, 16, convergence threshold on the window mean |error| (LSBs).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse: leave IDLE
- stop  in  1  pulse: enter DRAIN
- freeze_req  in  1  level: hold weights while asserted
- s_valid  in  1  input sample valid
- s_ready  out  1  scheduler accepts a sample this cycle
- s_signal  in  WIDTH  input sample x(n)
- s_desired  in  WIDTH  desired d(n)
- dp_signal_in  out  WIDTH  to datapath signal_in
- dp_desired_in  out  WIDTH  to datapath desired_in
- dp_adapt_en  out  1  to datapath mu-error gate, aligned to dp_error_d
- dp_filter_out_d  in  WIDTH  from datapath
- dp_error_d  in  WIDTH  from datapath
- m_valid  out  1  aligned result valid
- m_filter_out  out  WIDTH  registered filter output
- m_error  out  WIDTH  registered error
- state  out  3  IDLE=0, FILL=1, TRAIN=2, TRACK=3, FREEZE=4, DRAIN=5
- converged  out  1  window mean |error| < ERR_THR

Behaviour:
Reset (reset=0, async):
- state=IDLE. All outputs 0, including s_ready, converged and the tag pipeline. All counters are cleared.
- Datapath weights are not touched by this block.

Slot drive (every cycle):
- Accept when s_valid && s_ready.
- On accept: dp_signal_in/dp_desired_in = s_signal/s_desired, registered (1 clk), and tag=1.
- Otherwise: both outputs 0 and tag=0.
- tag[k] shifts each clock. tag[LAT] is the cycle in which dp_error_d belongs to that slot.

Alignment and results:
- m_valid/m_error/m_filter_out are registered from tag[LAT]/dp_error_d/dp_filter_out_d, giving latency LAT+1 from accept.
- The m_* data fields update only when tag[LAT]=1. m_valid pulses.
- dp_adapt_en = tag[LAT] && state in {TRAIN, TRACK, DRAIN-with-no-freeze}; combinational from registered state/tag.

States:
- IDLE:
  - s_ready=0.
  - start -> FILL; clears the train counter, window accumulator and converged.
- FILL:
  - s_ready=1, adapt 0.
  - Leaves for TRAIN on the first cycle tag[LAT]=1. That first slot is adapted, because TRAIN is entered combinationally for gating purposes: FILL with tag[LAT]=1 counts as TRAIN.
- TRAIN:
  - Counts tagged outputs.
  - At count==N_TRAIN -> TRACK.
- TRACK:
  - Adapt tagged outputs.
  - freeze_req=1 -> FREEZE.
- FREEZE:
  - adapt 0, s_ready=1, m_valid continues.
  - freeze_req=0 -> TRACK. A freeze_req asserted during TRAIN is deferred until TRACK.
- DRAIN:
  - s_ready=0, zeros driven.
  - In-flight tagged slots still produce m_valid.
  - Adapt follows the pre-stop freeze status (captured on stop).
  - -> IDLE when tag[1..LAT] are all 0.

Priority and boundary rules:
- Priority: stop > freeze_req > train count. stop in IDLE is ignored; start outside IDLE is ignored.
- s_valid=0 in any running state is a bubble: no count, no adapt, no m_valid.

Convergence monitor (TRAIN/TRACK/FREEZE, on each m_valid):
- |m_error| is saturated: -2^(WIDTH-1) -> 2^(WIDTH-1)-1.
- Accumulate into a WIDTH+WIN_LOG register. After 2^WIN_LOG samples: converged <= (acc>>WIN_LOG) < ERR_THR, then acc cleared.
- converged holds between windows and through DRAIN; it is cleared by start or reset.

Optional Feature:
- HSAF_AUTO_FREEZE_EN defined: TRACK with converged=1 enters FREEZE automatically. Exit occurs when a later window gives converged=0 and freeze_req=0.
- Undefined: only freeze_req causes FREEZE, and the converged flag is informational.

Test Plan:
- Reset mid-TRAIN (reset=0 for 1 clk after 100 samples) -> state=0, s_ready=0, m_valid=0, converged=0, dp_* =0 immediately (async).
- start, then continuous s_valid with x=16'h0400, d=16'h0200 -> first m_valid exactly LAT+1=11 clks after the first accept. First dp_adapt_en at 10 clks. TRACK after 4096 m_valid.
- Input gaps, s_valid pattern 1,0,0,1 -> m_valid pattern 1,0,0,1 shifted by 11 clks. dp_adapt_en=0 in the bubble slots. Train count advances by 2.
- freeze_req=1 during TRAIN (sample 50) -> stays TRAIN until 4096, then FREEZE with dp_adapt_en=0. freeze_req=0 -> TRACK next clk.
- stop with 10 samples in flight -> s_ready=0 next clk, exactly 10 m_valid pulses, then state=IDLE.
- Drive dp_error_d=8 constant for 256 outputs -> converged=1. With 16'h8000 (-32768) -> |e| saturates to 32767 and converged=0. With HSAF_AUTO_FREEZE_EN, TRACK -> FREEZE on the converged rise.
